conware_frame_ctrl: RTL and testbench



---
 rtl/conware_pkg.sv | 19 +
 rtl/conware_row_window.sv | 57 +++++
 rtl/conware_frame_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_conware_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conware_pkg.sv
// Shared definitions for the Conway frame sequencer.
//   STATE_W / state_t : FSM state encoding width and type
//   ST_*              : frame sequencer states
//   DEAD_CELL         : value of a cell outside the frame (top/bottom boundary)
package conware_pkg;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOAD_C   = 3'd1;
    localparam state_t ST_LOAD_B   = 3'd2;
    localparam state_t ST_ISSUE    = 3'd3;
    localparam state_t ST_WAIT_RES = 3'd4;
    localparam state_t ST_DONE     = 3'd5;

    localparam logic DEAD_CELL = 1'b0;

endpackage

// File: rtl/conware_row_window.sv
// Three-row sliding window (above / center / below) feeding the compute engine.
// Ports:
//   clk, rstn            : clock, synchronous active-low reset
//   i_clear_above        : force the above row dead (frame start)
//   i_load_center        : capture i_data into center
//   i_load_below         : capture i_data into below
//   i_shift              : above <= center, center <= below
//   i_zero_below         : force the below row dead (last row of frame)
//   i_data               : incoming row
//   o_above/center/below : window contents
module conware_row_window
    import conware_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clear_above,
    input  logic             i_load_center,
    input  logic             i_load_below,
    input  logic             i_shift,
    input  logic             i_zero_below,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_above,
    output logic [WIDTH-1:0] o_center,
    output logic [WIDTH-1:0] o_below
);

    localparam logic [WIDTH-1:0] DEAD_ROW = {WIDTH{DEAD_CELL}};

    logic [WIDTH-1:0] r_above;
    logic [WIDTH-1:0] r_center;
    logic [WIDTH-1:0] r_below;

    // Window registers; a shift may coincide with zero_below on the final row.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_above  <= DEAD_ROW;
            r_center <= DEAD_ROW;
            r_below  <= DEAD_ROW;
        end else begin
            if (i_clear_above)      r_above <= DEAD_ROW;
            else if (i_shift)       r_above <= r_center;

            if (i_load_center)      r_center <= i_data;
            else if (i_shift)       r_center <= r_below;

            if (i_zero_below)       r_below <= DEAD_ROW;
            else if (i_load_below)  r_below <= i_data;
        end
    end

    assign o_above  = r_above;
    assign o_center = r_center;
    assign o_below  = r_below;

endmodule

// File: rtl/conware_frame_ctrl.sv
// Frame sequencer: pulls rows from the row converter into a 3-row window,
// issues one compute request per row and forwards each result downstream.
// Optional macro CONWARE_GENCNT_EN enables the completed-generation counter;
// without it gen_count is tied to 0.
// Ports:
//   clk, rstn                         : clock, synchronous active-low reset
//   start, busy, frame_done, row_index : frame control / status
//   in_data/in_valid/in_ready          : row input stream
//   calc_above/center/below/valid/ready: compute request to the engine
//   res_data/res_valid/res_ready       : result from the engine
//   out_data/out_valid/out_ready       : result row downstream
//   gen_count                          : completed generations
module conware_frame_ctrl
    import conware_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned HEIGHT = 4,
    parameter int unsigned RWIDTH = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [RWIDTH-1:0] row_index,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  calc_above,
    output logic [WIDTH-1:0]  calc_center,
    output logic [WIDTH-1:0]  calc_below,
    output logic              calc_valid,
    input  logic              calc_ready,
    input  logic [WIDTH-1:0]  res_data,
    input  logic              res_valid,
    output logic              res_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       gen_count
);

    localparam logic [RWIDTH-1:0] LAST_ROW   = RWIDTH'(HEIGHT - 1);
    localparam logic [RWIDTH-1:0] ROWS_TOTAL = RWIDTH'(HEIGHT);
    localparam logic              SINGLE_ROW = (HEIGHT == 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [RWIDTH-1:0] r_rows_in;
    logic [RWIDTH-1:0] r_row_index;

    logic w_res_hs;
    logic w_last_row;
    logic w_more_rows;
    logic w_clear_above;
    logic w_load_center;
    logic w_load_below;
    logic w_shift;
    logic w_zero_below;

    // Window control decode
    assign w_res_hs      = (r_state == ST_WAIT_RES) & res_valid & out_ready;
    assign w_last_row    = (r_row_index == LAST_ROW);
    assign w_more_rows   = (r_rows_in < ROWS_TOTAL);
    assign w_clear_above = (r_state == ST_IDLE) & start;
    assign w_load_center = (r_state == ST_LOAD_C) & in_valid;
    assign w_load_below  = (r_state == ST_LOAD_B) & in_valid;
    assign w_shift       = w_res_hs & ~w_last_row;
    // Bottom boundary: no row below the last one, either on a single-row
    // frame or once every input row has already been consumed.
    assign w_zero_below  = (w_load_center & SINGLE_ROW) | (w_shift & ~w_more_rows);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (start)      w_next_state = ST_LOAD_C;
            ST_LOAD_C:   if (in_valid)   w_next_state = SINGLE_ROW ? ST_ISSUE : ST_LOAD_B;
            ST_LOAD_B:   if (in_valid)   w_next_state = ST_ISSUE;
            ST_ISSUE:    if (calc_ready) w_next_state = ST_WAIT_RES;
            ST_WAIT_RES: begin
                if (res_valid && out_ready) begin
                    if (w_last_row)       w_next_state = ST_DONE;
                    else if (w_more_rows) w_next_state = ST_LOAD_B;
                    else                  w_next_state = ST_ISSUE;
                end
            end
            ST_DONE:     w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs; result path is a passthrough while waiting.
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        in_ready   = 1'b0;
        calc_valid = 1'b0;
        res_ready  = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        case (r_state)
            ST_IDLE:     busy = 1'b0;
            ST_LOAD_C,
            ST_LOAD_B: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            ST_ISSUE: begin
                busy       = 1'b1;
                calc_valid = 1'b1;
            end
            ST_WAIT_RES: begin
                busy      = 1'b1;
                out_data  = res_data;
                out_valid = res_valid;
                res_ready = out_ready;
            end
            ST_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Row counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rows_in   <= '0;
            r_row_index <= '0;
        end else begin
            if (w_clear_above) begin
                r_rows_in   <= '0;
                r_row_index <= '0;
            end
            if (w_load_center) r_rows_in   <= RWIDTH'(1);
            if (w_load_below)  r_rows_in   <= r_rows_in + RWIDTH'(1);
            if (w_shift)       r_row_index <= r_row_index + RWIDTH'(1);
        end
    end

    assign row_index = r_row_index;

`ifdef CONWARE_GENCNT_EN
    logic [15:0] r_gen_count;

    // Completed generations, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!rstn)                    r_gen_count <= 16'd0;
        else if (r_state == ST_DONE)  r_gen_count <= r_gen_count + 16'd1;
    end

    assign gen_count = r_gen_count;
`else
    assign gen_count = 16'd0;
`endif

    conware_row_window #(
        .WIDTH (WIDTH)
    ) u_window (
        .clk           (clk),
        .rstn          (rstn),
        .i_clear_above (w_clear_above),
        .i_load_center (w_load_center),
        .i_load_below  (w_load_below),
        .i_shift       (w_shift),
        .i_zero_below  (w_zero_below),
        .i_data        (in_data),
        .o_above       (calc_above),
        .o_center      (calc_center),
        .o_below       (calc_below)
    );

endmodule

// File: tb/tb_conware_frame_ctrl.sv
// Bench for conware_frame_ctrl: a HEIGHT=3 instance driven with directed and
// randomized frames, plus a HEIGHT=1 instance for the single-row boundary.
module tb_conware_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int RW = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // HEIGHT=3 instance signals
    logic          start, busy, frame_done, in_valid, in_ready, calc_valid, calc_ready;
    logic          res_valid, res_ready, out_valid, out_ready;
    logic [RW-1:0] row_index;
    logic [W-1:0]  in_data, calc_above, calc_center, calc_below, res_data, out_data;
    logic [15:0]   gen_count;

    // HEIGHT=1 instance signals
    logic          start1, busy1, frame_done1, in_valid1, in_ready1, calc_valid1, calc_ready1;
    logic          res_valid1, res_ready1, out_valid1, out_ready1;
    logic [RW-1:0] row_index1;
    logic [W-1:0]  in_data1, calc_above1, calc_center1, calc_below1, res_data1, out_data1;
    logic [15:0]   gen_count1;

    conware_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .RWIDTH(RW)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .frame_done(frame_done),
        .row_index(row_index), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .calc_above(calc_above), .calc_center(calc_center), .calc_below(calc_below),
        .calc_valid(calc_valid), .calc_ready(calc_ready), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .gen_count(gen_count)
    );

    conware_frame_ctrl #(.WIDTH(W), .HEIGHT(1), .RWIDTH(RW)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .busy(busy1), .frame_done(frame_done1),
        .row_index(row_index1), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .calc_above(calc_above1), .calc_center(calc_center1), .calc_below(calc_below1),
        .calc_valid(calc_valid1), .calc_ready(calc_ready1), .res_data(res_data1),
        .res_valid(res_valid1), .res_ready(res_ready1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .gen_count(gen_count1)
    );

    int checks   = 0;
    int failures = 0;
    int exp_gen  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bump_gen();
`ifdef CONWARE_GENCNT_EN
        exp_gen = (exp_gen + 1) & 16'hFFFF;
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},       busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_in_ready"},   in_ready, 0);
        chk({tag, "_calc_valid"}, calc_valid, 0);
        chk({tag, "_res_ready"},  res_ready, 0);
        chk({tag, "_out_valid"},  out_valid, 0);
        chk({tag, "_row_index"},  row_index, 0);
        chk({tag, "_gen_count"},  gen_count, 0);
        chk({tag, "_window"},     {calc_above, calc_center, calc_below}, 0);
    endtask

    // mode 0: every handshake ready; 1: random valid/ready; 2: calc_ready
    // held low 5 cycles per request and out_ready low 4 cycles per result.
    task automatic run_frame(input int mode, input logic [W-1:0] rows [H]);
        logic [W-1:0] res [H];
        int  src = 0, req = 0, outs = 0, cyc = 0, first_calc = -1;
        int  cwait = 0, owait = 0, last_out = -10;
        bit  done = 0;
        for (int i = 0; i < H; i++) res[i] = W'($urandom);
        @(posedge clk); #1;
        start = 1'b1;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            in_valid = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
            in_data  = (src < H) ? rows[src] : W'($urandom);
            if (calc_valid) begin
                calc_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(1)) : (cwait >= 5);
                cwait++;
            end else begin
                calc_ready = (mode == 1) ? 1'($urandom_range(1)) : 1'b0;
            end
            res_valid = (mode == 1) ? 1'($urandom_range(1)) : 1'b1;
            res_data  = res[(outs < H) ? outs : 0];
            if (mode == 2) begin
                out_ready = (owait >= 4);
                if (req > outs) owait++;
            end else begin
                out_ready = (mode == 1) ? 1'($urandom_range(1)) : 1'b1;
            end
            @(negedge clk);
            chk("busy", busy, 1);
            chk("row_index", row_index, (outs < H) ? outs : H - 1);
            chk("frame_done", frame_done, cyc == last_out + 1);
            if (frame_done) done = 1;
            chk("out_valid", out_valid, res_valid && (req > outs));
            chk("res_ready", res_ready, out_ready && (req > outs));
            if (out_valid) chk("out_data", out_data, res[outs]);
            if (in_valid && in_ready) begin
                chk("input_within_frame", src < H, 1);
                src++;
            end
            if (calc_valid) begin
                if (first_calc < 0) first_calc = cyc;
                chk("request_within_frame", req < H, 1);
                if (req < H) begin
                    chk("calc_above",  calc_above,  (req > 0)     ? rows[req-1] : 0);
                    chk("calc_center", calc_center, rows[req]);
                    chk("calc_below",  calc_below,  (req < H - 1) ? rows[req+1] : 0);
                end
                if (calc_ready) begin
                    req++;
                    cwait = 0;
                end
            end
            if (out_valid && out_ready) begin
                outs++;
                owait = 0;
                if (outs == H) last_out = cyc;
            end
        end
        chk("frame_completed", done, 1);
        chk("request_count", req, H);
        chk("input_count", src, H);
        chk("output_count", outs, H);
        if (mode == 0) chk("first_calc_latency", first_calc, 3);
        if (done) bump_gen();
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_frame_done", frame_done, 0);
        chk("gen_count", gen_count, exp_gen);
        in_valid = 1'b0;
    endtask

    task automatic run_single_row(input logic [W-1:0] row);
        logic [W-1:0] res;
        int ins = 0, reqs = 0, outs = 0, cyc = 0;
        bit done = 0;
        res = W'($urandom);
        @(posedge clk); #1;
        start1 = 1'b1; in_valid1 = 1'b1; in_data1 = row; calc_ready1 = 1'b1;
        res_valid1 = 1'b1; res_data1 = res; out_ready1 = 1'b1;
        while (!done && cyc < 50) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            cyc++;
            @(negedge clk);
            if (in_valid1 && in_ready1) ins++;
            if (calc_valid1) begin
                chk("h1_calc_above",  calc_above1, 0);
                chk("h1_calc_center", calc_center1, row);
                chk("h1_calc_below",  calc_below1, 0);
                if (calc_ready1) reqs++;
            end
            if (frame_done1) begin
                chk("h1_done_after_result", outs, 1);
                done = 1;
            end
            if (out_valid1) chk("h1_out_data", out_data1, res);
            if (out_valid1 && out_ready1) outs++;
        end
        chk("h1_frame_completed", done, 1);
        chk("h1_input_count", ins, 1);
        chk("h1_request_count", reqs, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("h1_idle_busy", busy1, 0);
        in_valid1 = 1'b0;
    endtask

    logic [W-1:0] fr [H];
    int wait_cyc;

    initial begin
        rstn = 1'b0;
        start = 0; in_valid = 0; in_data = '0; calc_ready = 0; res_valid = 0; res_data = '0; out_ready = 0;
        start1 = 0; in_valid1 = 0; in_data1 = '0; calc_ready1 = 0; res_valid1 = 0; res_data1 = '0; out_ready1 = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("h1_reset_busy", busy1, 0);

        // Directed frame of identical rows at full speed
        fr = '{4'h2, 4'h2, 4'h2};
        run_frame(0, fr);

        // Single-row frame
        run_single_row(4'h9);

        // Engine and downstream stalls
        fr = '{4'h5, 4'hC, 4'h3};
        run_frame(2, fr);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < H; i++) fr[i] = W'($urandom);
            run_frame(1, fr);
        end
        run_single_row(W'($urandom));

        // Mid-frame start is ignored; reset at row 1 aborts the frame
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; in_data = 4'h7; calc_ready = 1'b1;
        res_valid = 1'b1; res_data = 4'h1; out_ready = 1'b1;
        wait_cyc = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            wait_cyc++;
            @(negedge clk);
        end while (row_index != 1 && wait_cyc < 50);
        chk("reach_row1", row_index, 1);
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        chk("start_ignored_busy", busy, 1);
        chk("start_ignored_row", row_index, 1);
        @(posedge clk); #1;
        start = 1'b0; rstn = 1'b0;
        in_valid = 0; calc_ready = 0; res_valid = 0; out_ready = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_gen = 0;
        @(negedge clk);
        chk_reset_outputs("midframe_reset");

        // Clean frames after reset
        fr = '{4'hA, 4'h6, 4'hF};
        run_frame(0, fr);
        for (int i = 0; i < H; i++) fr[i] = W'($urandom);
        run_frame(1, fr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
